// File: rtl/line_fill_memory.sv
`timescale 1ns/1ps
// Backing-memory responder for cache line refills and write-backs: one request, then a LINE_WORDS burst.
// The first beat follows acceptance by LATENCY wait cycles; refill beats stall on rsp_ready, write-back beats stall on wr_valid.
module line_fill_memory #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int MEM_ADDR_BITS = 12,
  parameter int LINE_WORDS    = 4,
  parameter int LATENCY       = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_done,
  output logic                  busy
);

  localparam int IDX_W  = MEM_ADDR_BITS - 2;
  localparam int DEPTH  = 1 << IDX_W;
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int LINE_W = IDX_W - BEAT_W;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [LAT_W-1:0]  LAT_INIT  = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RD,
    S_WR,
    S_ACK
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [LINE_W-1:0]       line_q;
  logic                    write_q;
  logic [BEAT_W-1:0]       beat_q;
  logic [LAT_W-1:0]        lat_q;
  logic [IDX_W-1:0]        word_idx;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    accept;
  logic                    rd_fire;
  logic                    wr_fire;
  logic                    unused_addr;

  assign accept   = req_valid && (state == S_IDLE);
  assign rd_fire  = (state == S_RD) && rsp_ready;
  assign wr_fire  = (state == S_WR) && wr_valid;
  // Line number concatenated with beat index: a burst can never cross its own line.
  assign word_idx = {line_q, beat_q};

  // Byte offset and the bits above the decoded window do not select a word.
  assign unused_addr = ^{req_addr[ADDR_WIDTH-1:MEM_ADDR_BITS], req_addr[BEAT_W+1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (LATENCY > 0) begin
            state_nxt = S_WAIT;
          end else begin
            state_nxt = req_write ? S_WR : S_RD;
          end
        end
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          state_nxt = write_q ? S_WR : S_RD;
        end
      end
      S_RD: begin
        if (rsp_ready && (beat_q == LAST_BEAT)) begin
          state_nxt = S_IDLE;
        end
      end
      S_WR: begin
        if (wr_valid && (beat_q == LAST_BEAT)) begin
          state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_last  = 1'b0;
    wr_ready  = 1'b0;
    wr_done   = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_RD: begin
        rsp_valid = 1'b1;
        rsp_data  = mem[word_idx];
        rsp_last  = (beat_q == LAST_BEAT);
      end
      S_WR: begin
        wr_ready = 1'b1;
      end
      S_ACK: begin
        wr_done = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q  <= '0;
      write_q <= 1'b0;
      beat_q  <= '0;
      lat_q   <= '0;
    end else begin
      if (accept) begin
        line_q  <= req_addr[MEM_ADDR_BITS-1:BEAT_W+2];
        write_q <= req_write;
        beat_q  <= '0;
        lat_q   <= LAT_INIT;
      end
      if ((state == S_WAIT) && (lat_q != '0)) begin
        lat_q <= lat_q - LAT_W'(1);
      end
      if (rd_fire || wr_fire) begin
        beat_q <= beat_q + BEAT_W'(1);
      end
    end
  end

  // Array contents survive reset; only the handshake in WR_BURST writes.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[word_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_line_fill_memory.sv
`timescale 1ns/1ps
// Directed bench for line_fill_memory: transaction-level memory model plus a per-cycle beat scoreboard.
module tb_line_fill_memory;

  localparam int LW  = 4;
  localparam int LAT = 3;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        wr_done;
  logic        busy;

  line_fill_memory #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_ADDR_BITS(12), .LINE_WORDS(LW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_done(wr_done),
    .busy(busy)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q [$];
  int          acc_q [$];
  logic [31:0] model_mem [1024];
  int          n_pass;
  int          n_total;
  int          cyc;
  int          done_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int line_base(input logic [31:0] a);
    int w;
    w = int'(a[11:2]);
    return w & ~(LW - 1);
  endfunction

  // Scoreboard: every visible refill beat must be the next expected word of the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_done) done_cnt++;
      if (req_valid && req_ready) acc_q.push_back(cyc + 1);
      chk("ready_vs_busy", {127'd0, req_ready}, {127'd0, !busy});
      chk("rd_wr_exclusive", {127'd0, rsp_valid && wr_ready}, 128'd0);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", {127'd0, rsp_valid}, 128'd0);
        end else begin
          chk("rsp_data", {96'd0, rsp_data}, {96'd0, exp_q[0].data});
          chk("rsp_last", {127'd0, rsp_last}, {127'd0, exp_q[0].last});
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic request(input logic wr, input logic [31:0] addr, output int t);
    int budget;
    budget = 50;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    t = -1;
    while (t < 0 && budget > 0) begin
      @(negedge clk); budget--;
      if (req_ready) t = cyc + 1;
    end
    if (t < 0) chk("req_accept_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wr_line(input logic [31:0] addr, input logic [127:0] dat, input bit gapped,
                         input int stop_after);
    int base, t, n, budget, dn0;
    bit ph;
    base = line_base(addr);
    dn0 = done_cnt;
    request(1'b1, addr, t);
    n = 0; budget = 100; ph = 1'b0;
    wr_valid = 1'b1;  // held during WAIT, where it must be ignored
    wr_data  = dat[31:0];
    while (n < stop_after && budget > 0) begin
      @(negedge clk); budget--;
      if (wr_valid && wr_ready) begin
        model_mem[base + n] = wr_data;
        n++;
      end
      @(posedge clk); #1;
      ph = ~ph;
      wr_valid = gapped ? ph : 1'b1;
      if (n < LW) wr_data = dat[32*n +: 32];
    end
    wr_valid = 1'b0;
    if (budget == 0) chk("wr_burst_timeout", 128'd0, 128'd1);
    if (stop_after == LW) begin
      repeat (4) @(negedge clk);
      chk("wr_done_pulses", 128'(done_cnt - dn0), 128'd1);
      chk("wr_idle_after", {127'd0, busy}, 128'd0);
    end
  endtask

  task automatic rd_line(input logic [31:0] addr, input int stall_beat, input int stalls,
                         output logic [127:0] got, output int lat);
    int base, t, n, budget, left;
    exp_t e;
    base = line_base(addr);
    for (int k = 0; k < LW; k++) begin
      e.data = model_mem[base + k];
      e.last = (k == LW - 1);
      exp_q.push_back(e);
    end
    got = '0; lat = -1; n = 0; budget = 100; left = stalls;
    rsp_ready = 1'b1;
    request(1'b0, addr, t);
    while (n < LW && budget > 0) begin
      @(negedge clk); budget--;
      if (rsp_valid) begin
        if (lat < 0) lat = cyc - t;
        if (rsp_ready) begin
          got[32*n +: 32] = rsp_data;
          n++;
        end
      end
      @(posedge clk); #1;
      if (rsp_valid && n == stall_beat && left > 0) begin
        rsp_ready = 1'b0;
        left--;
      end else begin
        rsp_ready = 1'b1;
      end
    end
    if (budget == 0) chk("rd_burst_timeout", 128'd0, 128'd1);
    @(negedge clk);
    chk("rd_idle_after", {127'd0, busy}, 128'd0);
    chk("rd_queue_drained", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    logic [127:0] got;
    int lat, budget, dn0;
    exp_t e;
    n_pass = 0; n_total = 0; cyc = 0; done_cnt = 0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    rsp_ready = 1'b1; wr_valid = 1'b0; wr_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {127'd0, req_ready}, 128'd1);
    chk("rst_busy",      {127'd0, busy},      128'd0);
    chk("rst_rsp_valid", {127'd0, rsp_valid}, 128'd0);
    chk("rst_wr_ready",  {127'd0, wr_ready},  128'd0);
    chk("rst_rsp_last",  {127'd0, rsp_last},  128'd0);
    chk("rst_wr_done",   {127'd0, wr_done},   128'd0);
    chk("rst_rsp_data",  {96'd0, rsp_data},   128'd0);
    rst = 1'b0;

    // Preload words 4..7, then refill via an unaligned address in that line
    wr_line(32'h010, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0, LW);
    chk("model_pin_w4", {96'd0, model_mem[4]}, 128'h11);
    chk("model_pin_w7", {96'd0, model_mem[7]}, 128'h44);
    rd_line(32'h014, -1, 0, got, lat);
    chk("refill_latency", 128'(lat), 128'd3);
    chk("refill_beat0", {96'd0, got[31:0]},   128'h11);
    chk("refill_beat1", {96'd0, got[63:32]},  128'h22);
    chk("refill_beat2", {96'd0, got[95:64]},  128'h33);
    chk("refill_beat3", {96'd0, got[127:96]}, 128'h44);

    // Back-pressure on beat 1 for two cycles
    rd_line(32'h014, 1, 2, got, lat);
    chk("stall_line", got, {32'h44, 32'h33, 32'h22, 32'h11});

    // Gapped write-back then refill from a different offset in the same line
    wr_line(32'h100, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b1, LW);
    rd_line(32'h10C, -1, 0, got, lat);
    chk("wb_then_refill", got, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

    // Address aliasing modulo 4 KiB
    rd_line(32'h1010, -1, 0, got, lat);
    chk("alias_line", got, {32'h44, 32'h33, 32'h22, 32'h11});

    // Second request held through the first burst is taken only once back in IDLE
    for (int k = 0; k < LW; k++) begin
      e.data = model_mem[4 + k];  e.last = (k == LW - 1); exp_q.push_back(e);
    end
    for (int k = 0; k < LW; k++) begin
      e.data = model_mem[64 + k]; e.last = (k == LW - 1); exp_q.push_back(e);
    end
    acc_q.delete();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h010;
    budget = 60;
    while (acc_q.size() < 1 && budget > 0) begin @(negedge clk); budget--; end
    @(posedge clk); #1;
    req_addr = 32'h100;
    while (acc_q.size() < 2 && budget > 0) begin @(negedge clk); budget--; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (exp_q.size() > 0 && budget > 0) begin @(negedge clk); budget--; end
    if (budget == 0) chk("b2b_timeout", 128'd0, 128'd1);
    @(negedge clk);
    chk("b2b_accepts", 128'(acc_q.size()), 128'd2);
    if (acc_q.size() == 2) chk("b2b_spacing", 128'(acc_q[1] - acc_q[0]), 128'd8);
    chk("b2b_idle", {127'd0, busy}, 128'd0);

    // Reset mid write-back after two beats
    wr_line(32'h200, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 1'b0, LW);
    dn0 = done_cnt;
    wr_line(32'h200, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 1'b0, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",      {127'd0, busy},      128'd0);
    chk("arst_req_ready", {127'd0, req_ready}, 128'd1);
    chk("arst_wr_ready",  {127'd0, wr_ready},  128'd0);
    chk("arst_rsp_valid", {127'd0, rsp_valid}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", 128'(done_cnt - dn0), 128'd0);
    rd_line(32'h200, -1, 0, got, lat);
    chk("abort_partial", got, {32'hB3, 32'hB2, 32'hC1, 32'hC0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
